// File: rtl/mips_pkg.sv
// Shared types and constants for the GPR writeback path.
//   wb_req_t : one pending register-file write {rd, data}
//   bypass() : forwarding mux shared by both read ports
package mips_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_OVF  = 5'd30;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Value the register file will hold at rd_a after this cycle's write.
  // An overflow write only sets bit 0 of $30; writes to $0 never land.
  function automatic logic [DATA_W-1:0] bypass(
    input logic              en,
    input logic              set_ovf,
    input logic [REG_W-1:0]  wr_rd,
    input logic [DATA_W-1:0] wr_data,
    input logic [REG_W-1:0]  rd_a,
    input logic [DATA_W-1:0] raw
  );
    if (en && !set_ovf && wr_rd == rd_a && rd_a != REG_ZERO) return wr_data;
    if (en && set_ovf && rd_a == REG_OVF)                     return raw | 32'd1;
    return raw;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t holding LL results awaiting the write port.
//   push/din : enqueue (ignored when full)
//   pop      : dequeue head (ignored when empty)
//   head     : current head entry, valid when !empty
//   full/empty : derived from registered occupancy only
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;   // one extra bit so full and empty are distinct
  logic          push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset; contents are only observed when !empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gpr_wb_ctrl.sv
// Writeback controller for the GPR write port.
//   ALU results (alu_*) always take the port; LL results (ll_*) are queued
//   and drained on cycles without an ALU write.
//   ll_issue/ll_issue_rd : mark a register busy until its LL write commits
//   busy                 : per-register outstanding-LL scoreboard
//   gpr_*                : register-file write port (en, set_overflow_bit, reg_W1, W1)
//   rd_a*/gpr_R* -> fwd_R* : read data with this cycle's write bypassed in
module gpr_wb_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_ovf,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_W-1:0]  ll_rd,
  input  logic [DATA_W-1:0] ll_data,
  input  logic              ll_issue,
  input  logic [REG_W-1:0]  ll_issue_rd,
  output logic [31:0]       busy,
  output logic              gpr_en,
  output logic              gpr_set_ovf,
  output logic [REG_W-1:0]  gpr_reg_W1,
  output logic [DATA_W-1:0] gpr_W1,
  input  logic [REG_W-1:0]  rd_a1,
  input  logic [REG_W-1:0]  rd_a2,
  input  logic [DATA_W-1:0] gpr_R1,
  input  logic [DATA_W-1:0] gpr_R2,
  output logic [DATA_W-1:0] fwd_R1,
  output logic [DATA_W-1:0] fwd_R2
);
  wb_req_t     head;
  logic        full, empty, pop;
  logic [31:0] busy_nxt;

  // LL head drains only on cycles the ALU leaves the port free.
  assign pop      = ~rst & ~alu_valid & ~empty;
  assign ll_ready = ~full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ll_valid),
    .din   ('{rd: ll_rd, data: ll_data}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    gpr_en      = 1'b0;
    gpr_set_ovf = 1'b0;
    gpr_reg_W1  = '0;
    gpr_W1      = '0;
    if (!rst) begin
      if (alu_valid) begin
        gpr_en      = 1'b1;
        gpr_set_ovf = alu_ovf;
        gpr_reg_W1  = alu_rd;
        gpr_W1      = alu_data;
      end else if (!empty) begin
        gpr_en      = 1'b1;
        gpr_reg_W1  = head.rd;
        gpr_W1      = head.data;
      end
    end
  end

  // Clear on commit first so a same-cycle issue to that rd re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (ll_issue && ll_issue_rd != REG_ZERO) busy_nxt[ll_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign fwd_R1 = bypass(gpr_en, gpr_set_ovf, gpr_reg_W1, gpr_W1, rd_a1, gpr_R1);
  assign fwd_R2 = bypass(gpr_en, gpr_set_ovf, gpr_reg_W1, gpr_W1, rd_a2, gpr_R2);
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
module tb_gpr_wb_ctrl;
  import mips_pkg::*;
  localparam int DEPTH = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid, alu_ovf, ll_valid, ll_issue, ll_ready;
  logic [4:0] alu_rd, ll_rd, ll_issue_rd, rd_a1, rd_a2, gpr_reg_W1;
  logic [31:0] alu_data, ll_data, gpr_R1, gpr_R2, busy, gpr_W1, fwd_R1, fwd_R2;
  logic gpr_en, gpr_set_ovf;

  int checks = 0, errors = 0;

  // Reference model: a queue of pending LL writes and a busy bitmap.
  wb_req_t     mq[$];
  logic [31:0] mbusy = '0;

  gpr_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ovf(alu_ovf), .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd),
    .ll_data(ll_data), .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd), .busy(busy),
    .gpr_en(gpr_en), .gpr_set_ovf(gpr_set_ovf), .gpr_reg_W1(gpr_reg_W1), .gpr_W1(gpr_W1),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .gpr_R1(gpr_R1), .gpr_R2(gpr_R2),
    .fwd_R1(fwd_R1), .fwd_R2(fwd_R2)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0; alu_ovf = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0; ll_issue = 0; ll_issue_rd = 0;
    rd_a1 = 0; rd_a2 = 0; gpr_R1 = 0; gpr_R2 = 0;
  endtask

  // Advance the model by the rules for one edge, then clock to the next negedge.
  task automatic step();
    bit pop, acc;
    if (rst) begin
      mq.delete(); mbusy = '0;
    end else begin
      pop = !alu_valid && mq.size() > 0;
      acc = ll_valid && mq.size() < DEPTH;
      if (pop) begin mbusy[mq[0].rd] = 1'b0; void'(mq.pop_front()); end
      if (ll_issue && ll_issue_rd != 0) mbusy[ll_issue_rd] = 1'b1;
      if (acc) mq.push_back('{rd: ll_rd, data: ll_data});
      mbusy[0] = 1'b0;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs(); alu_valid = 1; alu_rd = 3; alu_data = 32'h55; rst = 1;
    #1;
    checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", gpr_en); end
    checks++; if (gpr_set_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", gpr_set_ovf); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ll_ready); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
    step(); idle_inputs(); rst = 0; #1;
    checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL post_reset_en got %b exp 0", gpr_en); end
    step();
  endtask

  task automatic test_alu_write();
    idle_inputs(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    rd_a1 = 5; gpr_R1 = 32'h1111; rd_a2 = 6; gpr_R2 = 32'h2222; #1;
    checks++; if (gpr_en !== 1'b1) begin errors++; $display("FAIL alu_en got %b exp 1", gpr_en); end
    checks++; if (gpr_reg_W1 !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", gpr_reg_W1); end
    checks++; if (gpr_W1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", gpr_W1); end
    checks++; if (gpr_set_ovf !== 1'b0) begin errors++; $display("FAIL alu_ovf got %b exp 0", gpr_set_ovf); end
    checks++; if (fwd_R1 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_fwd1 got %h exp deadbeef", fwd_R1); end
    checks++; if (fwd_R2 !== 32'h2222) begin errors++; $display("FAIL alu_fwd2 got %h exp 2222", fwd_R2); end
    step();
    // Writes to $0 never bypass.
    alu_rd = 0; alu_data = 32'hFFFF; rd_a1 = 0; gpr_R1 = 32'h0; #1;
    checks++; if (fwd_R1 !== 32'h0) begin errors++; $display("FAIL alu_zero_fwd got %h exp 0", fwd_R1); end
    step(); idle_inputs();
  endtask

  task automatic test_overflow();
    idle_inputs(); alu_valid = 1; alu_ovf = 1; alu_rd = 7; alu_data = 32'hABCD;
    rd_a1 = 7; gpr_R1 = 32'h55; rd_a2 = 30; gpr_R2 = 32'h10; #1;
    checks++; if (gpr_set_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", gpr_set_ovf); end
    checks++; if (fwd_R2 !== 32'h11) begin errors++; $display("FAIL ovf_fwd2 got %h exp 11", fwd_R2); end
    checks++; if (fwd_R1 !== 32'h55) begin errors++; $display("FAIL ovf_fwd1 got %h exp 55", fwd_R1); end
    step(); idle_inputs();
  endtask

  task automatic test_contention();
    idle_inputs(); ll_issue = 1; ll_issue_rd = 9; step();
    ll_issue = 0; #1;
    checks++; if (busy !== 32'h200) begin errors++; $display("FAIL cont_busy_set got %h exp 200", busy); end
    alu_valid = 1; alu_rd = 3; alu_data = 1; ll_valid = 1; ll_rd = 9; ll_data = 32'h1234; #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL cont_ready got %b exp 1", ll_ready); end
    step(); ll_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (gpr_reg_W1 !== 5'd3) begin errors++; $display("FAIL cont_stall_rd got %0d exp 3", gpr_reg_W1); end
      checks++; if (busy !== 32'h200) begin errors++; $display("FAIL cont_stall_busy got %h exp 200", busy); end
      step();
    end
    alu_valid = 0; #1;
    checks++; if (gpr_en !== 1'b1 || gpr_reg_W1 !== 5'd9 || gpr_W1 !== 32'h1234)
      begin errors++; $display("FAIL cont_ll_write got en=%b rd=%0d d=%h exp 1/9/1234", gpr_en, gpr_reg_W1, gpr_W1); end
    step(); #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL cont_busy_clr got %h exp 0", busy); end
    checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL cont_idle got %b exp 0", gpr_en); end
    idle_inputs();
  endtask

  task automatic test_full_queue();
    logic [31:0] d [3] = '{32'hA0, 32'hB1, 32'hC2};
    idle_inputs(); alu_valid = 1; alu_rd = 1;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1; ll_rd = 5'(10 + i); ll_data = d[i]; #1;
      checks++; if (ll_ready !== (i < 2)) begin errors++; $display("FAIL full_ready%0d got %b exp %b", i, ll_ready, i < 2); end
      step();
    end
    alu_valid = 0; ll_rd = 12; ll_data = d[2]; #1;   // still offering the third result
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop got %b exp 0", ll_ready); end
    checks++; if (gpr_W1 !== d[0] || gpr_reg_W1 !== 5'd10) begin errors++; $display("FAIL full_pop0 got %h exp %h", gpr_W1, d[0]); end
    step(); #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", ll_ready); end
    checks++; if (gpr_W1 !== d[1]) begin errors++; $display("FAIL full_pop1 got %h exp %h", gpr_W1, d[1]); end
    step(); ll_valid = 0; #1;
    checks++; if (gpr_W1 !== d[2] || gpr_reg_W1 !== 5'd12) begin errors++; $display("FAIL full_pop2 got %h exp %h", gpr_W1, d[2]); end
    step(); #1;
    checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", gpr_en); end
  endtask

  task automatic test_collision();
    idle_inputs(); ll_issue = 1; ll_issue_rd = 4; step();
    ll_issue = 0; alu_valid = 1; ll_valid = 1; ll_rd = 4; ll_data = 32'h44; step();
    ll_valid = 0; alu_valid = 0; ll_issue = 1; ll_issue_rd = 4; #1;
    checks++; if (gpr_reg_W1 !== 5'd4 || gpr_en !== 1'b1) begin errors++; $display("FAIL coll_pop got rd=%0d exp 4", gpr_reg_W1); end
    step(); ll_issue_rd = 0; #1;
    checks++; if (busy !== 32'h10) begin errors++; $display("FAIL coll_busy got %h exp 10", busy); end
    step(); ll_issue = 0; #1;
    checks++; if (busy !== 32'h10) begin errors++; $display("FAIL busy0_stays_clear got %h exp 10", busy); end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); rst = 1; step(); rst = 0;
    ll_issue = 1; ll_issue_rd = 4; step();
    ll_issue_rd = 9; step(); ll_issue = 0; #1;
    checks++; if (busy !== 32'h210) begin errors++; $display("FAIL rmid_busy got %h exp 210", busy); end
    alu_valid = 1; alu_rd = 2; ll_valid = 1; ll_rd = 4; ll_data = 32'hAA; step();
    ll_rd = 9; ll_data = 32'hBB; step(); ll_valid = 0; #1;
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %b exp 0", ll_ready); end
    #2 rst = 1; #1;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", ll_ready); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rmid_busy_clr got %h exp 0", busy); end
    checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL rmid_en got %b exp 0", gpr_en); end
    step(); idle_inputs(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gpr_en !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got %b exp 0", i, gpr_en); end
      step();
    end
  endtask

  task automatic test_random();
    logic [4:0] pick [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 30};
    logic e_en, e_ovf; logic [4:0] e_rd; logic [31:0] e_d, e_f1, e_f2;
    idle_inputs(); rst = 1; step(); rst = 0;
    for (int n = 0; n < 500; n++) begin
      alu_valid = ($urandom_range(0, 2) == 0); alu_ovf = ($urandom_range(0, 5) == 0);
      alu_rd = pick[$urandom_range(0, 8)]; alu_data = $urandom;
      ll_valid = $urandom_range(0, 1); ll_rd = pick[$urandom_range(0, 8)]; ll_data = $urandom;
      ll_issue = $urandom_range(0, 1); ll_issue_rd = pick[$urandom_range(0, 8)];
      rd_a1 = pick[$urandom_range(0, 8)]; rd_a2 = pick[$urandom_range(0, 8)];
      gpr_R1 = $urandom; gpr_R2 = $urandom; #1;
      e_en = 0; e_ovf = 0; e_rd = 0; e_d = 0;
      if (alu_valid) begin e_en = 1; e_ovf = alu_ovf; e_rd = alu_rd; e_d = alu_data; end
      else if (mq.size() > 0) begin e_en = 1; e_rd = mq[0].rd; e_d = mq[0].data; end
      e_f1 = gpr_R1; e_f2 = gpr_R2;
      if (e_en && e_ovf) begin
        if (rd_a1 == 30) e_f1 = gpr_R1 | 1;
        if (rd_a2 == 30) e_f2 = gpr_R2 | 1;
      end else if (e_en) begin
        if (rd_a1 == e_rd && rd_a1 != 0) e_f1 = e_d;
        if (rd_a2 == e_rd && rd_a2 != 0) e_f2 = e_d;
      end
      checks++; if ({gpr_en, gpr_set_ovf, gpr_reg_W1, gpr_W1} !== {e_en, e_ovf, e_rd, e_d})
        begin errors++; $display("FAIL rnd_wr@%0d got %b/%b/%0d/%h exp %b/%b/%0d/%h", n, gpr_en, gpr_set_ovf, gpr_reg_W1, gpr_W1, e_en, e_ovf, e_rd, e_d); end
      checks++; if (ll_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d got %b exp %b", n, ll_ready, mq.size() < DEPTH); end
      checks++; if (busy !== mbusy) begin errors++; $display("FAIL rnd_busy@%0d got %h exp %h", n, busy, mbusy); end
      checks++; if (fwd_R1 !== e_f1 || fwd_R2 !== e_f2)
        begin errors++; $display("FAIL rnd_fwd@%0d got %h/%h exp %h/%h", n, fwd_R1, fwd_R2, e_f1, e_f2); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_overflow();
    test_contention();
    test_full_queue();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Writeback controller on the write side of the general-purpose register file. It merges single-cycle ALU results and long-latency (LL) unit results onto the file's single write port (`W1`, `reg_W1`, `set_overflow_bit`, `en`). It also keeps a per-register busy scoreboard for outstanding LL writes and provides same-cycle read bypass so the issue stage sees values committed at the next edge.

## Interface
- `DEPTH`, default 2: LL result queue depth; power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result present this cycle; no backpressure.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ovf` in 1: ALU overflow; request to set bit 0 of $30 instead of writing `alu_rd`.
- `ll_valid` in 1: LL result offered.
- `ll_ready` out 1: queue can accept; equals not-full.
- `ll_rd` in 5: LL destination register.
- `ll_data` in 32: LL result.
- `ll_issue` in 1: LL operation issued this cycle.
- `ll_issue_rd` in 5: destination of the issued LL operation.
- `busy` out 32: bit r set means an LL write to r is outstanding.
- `gpr_en` out 1: drives register-file `en`.
- `gpr_set_ovf` out 1: drives `set_overflow_bit`.
- `gpr_reg_W1` out 5: drives `reg_W1`.
- `gpr_W1` out 32: drives `W1`.
- `rd_a1`, `rd_a2` in 5 each: read addresses, same as those driving the register file.
- `gpr_R1`, `gpr_R2` in 32 each: raw register-file read data.
- `fwd_R1`, `fwd_R2` out 32 each: bypassed read data.

## Operation
- One register-file write per cycle. The ALU always wins. The queue head is written only when `alu_valid`=0.
- **ALU write**, when `alu_valid`=1:
  - `gpr_en`=1, `gpr_reg_W1`=`alu_rd`, `gpr_W1`=`alu_data`.
  - `gpr_set_ovf`=`alu_ovf`. With ovf set, the register file ignores `rd`, so the ALU result is discarded.
- **LL write**, when `alu_valid`=0 and the queue is not empty:
  - `gpr_en`=1, `gpr_set_ovf`=0, outputs taken from the queue head.
  - The head is popped at the edge.
- **Idle**: `gpr_en`=0, `gpr_set_ovf`=0, `gpr_reg_W1`=0, `gpr_W1`=0.
- **Queue**:
  - Push on `ll_valid & ll_ready`.
  - `ll_ready`=~full, computed from registered state only. A full queue rejects a push even when a pop happens in the same cycle.
  - There is no cut-through: every LL result passes through the queue.
- **rd=0 entries**: queued and popped normally with `gpr_en`=1. The register file drops writes to $0.
- **Scoreboard**:
  - Set `busy[ll_issue_rd]` on `ll_issue` when `ll_issue_rd`≠0.
  - Clear `busy[rd]` when an entry with that rd is popped.
  - If set and clear hit the same rd in one cycle, the set wins.
  - `busy[0]` is always 0.
- **Bypass**, per port p:
  - If `gpr_en & ~gpr_set_ovf & gpr_reg_W1==rd_ap & rd_ap≠0`: `fwd_Rp`=`gpr_W1`.
  - Else if `gpr_en & gpr_set_ovf & rd_ap==30`: `fwd_Rp`=`gpr_Rp | 1`.
  - Else: `fwd_Rp`=`gpr_Rp`.
- **Issue-stage obligations**, unchecked here:
  - Do not issue an LL op to a register that is already busy.
  - Do not let an ALU op write a busy register (WAW).
- **Reset** (async, immediate):
  - Queue empty, `busy`=0, `ll_ready`=1.
  - While `rst` is high, `gpr_en`=`gpr_set_ovf`=0.

## Timing
- All GPR-side outputs and `fwd_*` are combinational from current inputs and registered state.
- ALU result is visible in the register file after 1 edge.
- LL result is visible after at least 2 edges from acceptance: 1 edge to enqueue, 1 edge to write. Each cycle with `alu_valid`=1 adds one cycle of delay.
- `busy` updates at the edge after `ll_issue`, and clears at the edge that commits the write.
- Queue pointers wrap modulo DEPTH; a count of log2(DEPTH)+1 bits distinguishes full from empty.
- Reset asserted mid-operation discards queued results and busy state.

## Structure
- Shared package `mips_pkg`:
  - `REG_W`=5, `DATA_W`=32.
  - `REG_OVF`=5'd30, `REG_ZERO`=5'd0.
  - Struct `wb_req_t` {rd, data}.
- Sub-module `wb_fifo`: parameterised synchronous FIFO of `wb_req_t` with push/pop/full/empty and async reset. The scoreboard and bypass stay in `gpr_wb_ctrl`.

## Test plan
- **ALU write**: `alu_valid`=1, rd=5, data=0xDEADBEEF → `gpr_en`=1, `gpr_reg_W1`=5, `gpr_W1`=0xDEADBEEF. With `rd_a1`=5 that cycle, `fwd_R1`=0xDEADBEEF.
- **Overflow**: `alu_valid`=1, `alu_ovf`=1, rd=7, `rd_a2`=30, `gpr_R2`=0x10 → `gpr_set_ovf`=1, `fwd_R2`=0x11.
- **Contention**:
  - `ll_issue` rd=9, then the LL result {9, 0x1234} is accepted.
  - `alu_valid` is held at 1 for 3 cycles → LL write stalls.
  - On the first idle cycle, `gpr_reg_W1`=9 and `gpr_W1`=0x1234; `busy[9]` clears at that edge.
- **Full queue** (DEPTH=2): 3 back-to-back `ll_valid` with the ALU busy → `ll_ready`=0 after 2 pushes. The third result is held and accepted after the first pop; order is preserved.
- **Set/clear collision**: pop of rd=4 in the same cycle as `ll_issue` rd=4 → `busy[4]`=1 afterward.
- **Reset mid-operation**: `rst` pulsed with 2 entries queued and `busy`=0x0000_0210 → immediately `ll_ready`=1, `busy`=0, `gpr_en`=0. No stale writes occur after release.
